// File: rtl/retospect_lif_cell.sv
// Leaky integrate-and-fire neuron cell with serial config chain and refractory period.
// Define RETOSPECT_SIGNED_WEIGHTS_EN for two's complement weights with a floor at 0.
module retospect_lif_cell #(
  parameter int N_DEND = 4,
  parameter int W_BITS = 3,
  parameter int P_BITS = 6,
  parameter int R_BITS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reset_nn,
  input  logic              config_en,
  input  logic              bs_in,
  output logic              bs_out,
  input  logic [7:0]        clockbus,
  input  logic [N_DEND-1:0] dendrite,
  output logic              axon
);

  localparam int L    = N_DEND * W_BITS + P_BITS + 3 + R_BITS;
  localparam int SW   = P_BITS + N_DEND + W_BITS;
  localparam int DS_T = R_BITS + 3 - 1;
  localparam int TH_T = P_BITS + 3 + R_BITS - 1;

  localparam logic [SW-1:0] PMAX =
    {{(SW - P_BITS){1'b0}}, {P_BITS{1'b1}}};

  // w[0] sits at the top of the chain; refr_len LSB drives bs_out
  logic [L-1:0]      chain_q;
  logic [L-1:0]      chain_d;
  logic [P_BITS-1:0] pot_q;
  logic [P_BITS-1:0] pot_d;
  logic [R_BITS-1:0] refr_cnt_q;
  logic [R_BITS-1:0] refr_cnt_d;
  logic              axon_q;
  logic              axon_d;

  logic [W_BITS-1:0] w [N_DEND];
  logic [P_BITS-1:0] thr;
  logic [2:0]        decay_sel;
  logic [R_BITS-1:0] refr_len;

  logic [P_BITS-1:0] p_dec;
  logic [SW-1:0]     acc;
  logic [SW-1:0]     w_ext;
  logic [P_BITS-1:0] s_sat;
  logic              fire;

  always_comb begin
    for (int i = 0; i < N_DEND; i++) begin
      w[i] = chain_q[L - 1 - i * W_BITS -: W_BITS];
    end
  end

  assign thr       = chain_q[TH_T -: P_BITS];
  assign decay_sel = chain_q[DS_T -: 3];
  assign refr_len  = chain_q[R_BITS-1:0];

  always_comb begin
    p_dec = clockbus[decay_sel] ? (pot_q >> 1) : pot_q;
    acc   = {{(SW - P_BITS){1'b0}}, p_dec};
    w_ext = '0;
    for (int i = 0; i < N_DEND; i++) begin
`ifdef RETOSPECT_SIGNED_WEIGHTS_EN
      w_ext = {{(SW - W_BITS){w[i][W_BITS-1]}}, w[i]};
`else
      w_ext = {{(SW - W_BITS){1'b0}}, w[i]};
`endif
      if (dendrite[i]) begin
        acc = acc + w_ext;
      end
    end
  end

  always_comb begin
    s_sat = acc[P_BITS-1:0];
`ifdef RETOSPECT_SIGNED_WEIGHTS_EN
    if (acc[SW-1]) begin
      s_sat = '0;
    end else if (acc > PMAX) begin
      s_sat = '1;
    end
`else
    if (acc > PMAX) begin
      s_sat = '1;
    end
`endif
    fire = (thr != '0) && (s_sat >= thr);
  end

  always_comb begin
    chain_d    = chain_q;
    pot_d      = pot_q;
    refr_cnt_d = refr_cnt_q;
    axon_d     = 1'b0;
    if (reset_nn) begin
      pot_d      = '0;
      refr_cnt_d = '0;
    end else if (config_en) begin
      chain_d = {bs_in, chain_q[L-1:1]};
    end else if (refr_cnt_q != '0) begin
      refr_cnt_d = refr_cnt_q - R_BITS'(1);
      pot_d      = '0;
    end else if (fire) begin
      axon_d     = 1'b1;
      pot_d      = '0;
      refr_cnt_d = refr_len;
    end else begin
      pot_d = s_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q    <= '0;
      pot_q      <= '0;
      refr_cnt_q <= '0;
      axon_q     <= 1'b0;
    end else begin
      chain_q    <= chain_d;
      pot_q      <= pot_d;
      refr_cnt_q <= refr_cnt_d;
      axon_q     <= axon_d;
    end
  end

  assign bs_out = chain_q[0];
  assign axon   = axon_q;

endmodule
